// File: rtl/bus_xfer_ctrl.sv
// Bus-transfer initiator: queues (src, dst) move requests and sequences the
// per-unit ENABLE/LOAD strobes so one unit drives the shared bus and one captures it.

package bus_xfer_pkg;
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    ENABLE = 2'd1,
    LOAD   = 2'd2
  } memory_op_e;
endpackage

module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int N_UNITS    = 8,
  parameter int UNIT_W     = $clog2(N_UNITS),
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  // req_valid/req_ready: a request moves on the posedge where both are high;
  // req_ready depends only on FIFO occupancy, and the requester holds a refused request.
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [UNIT_W-1:0]          req_src,
  input  logic [UNIT_W-1:0]          req_dst,
  input  logic [7:0]                 bus_in,
  output memory_op_e [N_UNITS-1:0]   ops,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 done_data,
  output logic                       err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = FIFO_DEPTH[PTR_W:0];
  localparam logic [UNIT_W:0] N_LIM   = N_UNITS[UNIT_W:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e                   state, next_state;
  logic [UNIT_W-1:0]        src_mem [FIFO_DEPTH];
  logic [UNIT_W-1:0]        dst_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [PTR_W:0]           count;
  logic                     push, pop, head_ok, done_d, err_d, capture;
  logic [UNIT_W-1:0]        head_src, head_dst, cur_src, cur_dst, nxt_src, nxt_dst;
  memory_op_e [N_UNITS-1:0] ops_d;

  assign req_ready = (count != DEPTH_C);
  assign push      = req_valid && req_ready;
  assign head_src  = src_mem[rd_ptr];
  assign head_dst  = dst_mem[rd_ptr];
  assign head_ok   = (head_src != head_dst) && ({1'b0, head_src} < N_LIM) &&
                     ({1'b0, head_dst} < N_LIM);
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      src_mem[wr_ptr] <= req_src;
      dst_mem[wr_ptr] <= req_dst;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // COMMIT chains straight into the next PRIME when a valid request is waiting;
  // an invalid head falls back to IDLE, which rejects it with an err pulse.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    err_d      = 1'b0;
    done_d     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head_ok) next_state = PRIME;
          else         err_d      = 1'b1;
        end
      end
      PRIME:  next_state = COMMIT;
      COMMIT: begin
        capture = 1'b1;
        done_d  = 1'b1;
        if ((count != '0) && head_ok) begin
          pop        = 1'b1;
          next_state = PRIME;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so ops never glitch.
  always_comb begin
    nxt_src = pop ? head_src : cur_src;
    nxt_dst = pop ? head_dst : cur_dst;
    for (int i = 0; i < N_UNITS; i++) ops_d[i] = NONE;
    if (next_state == PRIME) begin
      ops_d[nxt_src] = ENABLE;
    end else if (next_state == COMMIT) begin
      ops_d[nxt_src] = ENABLE;
      ops_d[nxt_dst] = LOAD;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      done_data <= 8'h00;
      for (int i = 0; i < N_UNITS; i++) ops[i] <= NONE;
    end else begin
      state   <= next_state;
      ops     <= ops_d;
      done    <= done_d;
      err     <= err_d;
      cur_src <= nxt_src;
      cur_dst <= nxt_dst;
      if (capture) done_data <= bus_in;
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: behavioural bus units around the DUT plus a queue-based
// model that predicts every done_data from the unit contents in request order.

module tb_bus_xfer_ctrl;
  import bus_xfer_pkg::*;

  // Six units so that an index >= N_UNITS still fits in the 3-bit request fields.
  localparam int N  = 6;
  localparam int UW = 3;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [UW-1:0]      req_src = '0, req_dst = '0;
  logic [7:0]         bus_in;
  memory_op_e [N-1:0] ops;
  logic               busy, done, err;
  logic [7:0]         done_data;

  bus_xfer_ctrl #(.N_UNITS(N), .UNIT_W(UW), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .bus_in(bus_in), .ops(ops),
    .busy(busy), .done(done), .done_data(done_data), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- bus units (environment) ----------------
  logic [7:0]    unit_mem [N];
  logic [7:0]    latch [N];
  logic          en_d [N];
  logic [7:0]    junk;
  logic          pre_en = 1'b0;
  logic [UW-1:0] pre_idx = '0;
  logic [7:0]    pre_val = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      junk <= 8'h5A;
      for (int i = 0; i < N; i++) en_d[i] <= 1'b0;
    end else begin
      junk <= 8'($urandom);
      if (pre_en) unit_mem[pre_idx] <= pre_val;
      for (int i = 0; i < N; i++) begin
        en_d[i] <= (ops[i] == ENABLE);
        if (ops[i] == ENABLE) latch[i] <= unit_mem[i];
        if (ops[i] == LOAD) unit_mem[i] <= bus_in;
      end
    end
  end

  // A unit drives its latched copy only from its second consecutive ENABLE cycle.
  always_comb begin
    bus_in = junk;
    for (int i = 0; i < N; i++)
      if (ops[i] == ENABLE && en_d[i]) bus_in = latch[i];
  end

  // ---------------- reference model and scoreboard ----------------
  logic [2*UW-1:0] exp_q[$];
  logic [7:0]      model_mem [N];
  int              exp_err = 0, err_seen = 0, done_total = 0, cyc = 0;
  logic            t3_active = 1'b0, t4_active = 1'b0;
  int              done_times[$];
  int              t4_ops = 0, t4_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      int n_en, n_ld;
      logic [2*UW-1:0] p;
      logic [7:0] expd;
      if (pre_en) model_mem[pre_idx] = pre_val;
      if (done) begin
        done_total++;
        if (t3_active) done_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          p    = exp_q.pop_front();
          expd = model_mem[p[2*UW-1:UW]];
          check("done_data", done_data, expd);
          model_mem[p[UW-1:0]] = expd;
        end
      end
      if (req_valid && req_ready) begin
        if (req_src != req_dst && req_src < N && req_dst < N) exp_q.push_back({req_src, req_dst});
        else exp_err++;
      end
      if (err) begin
        err_seen++;
        if (t4_active) t4_err++;
      end
      n_en = 0;
      n_ld = 0;
      for (int i = 0; i < N; i++) begin
        if (ops[i] == ENABLE) n_en++;
        if (ops[i] == LOAD) n_ld++;
      end
      check("one_enable", n_en <= 1, 1);
      check("one_load", n_ld <= 1, 1);
      if (t4_active && (n_en + n_ld) != 0) t4_ops++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input int idx, input logic [7:0] val);
    @(posedge clock); #1;
    pre_en = 1'b1; pre_idx = UW'(idx); pre_val = val;
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  task automatic send(input int s, input int d);
    bit ok = 0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_src = UW'(s); req_dst = UW'(d);
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; req_valid = 1'b0; end
  endtask

  task automatic drain();
    bit ok = 0;
    idle(1);
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  task automatic wait_op(input int idx, input memory_op_e op, input string tag);
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (ops[idx] == op) begin ok = 1; break; end
    end
    if (!ok) check(tag, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, s, d;
    repeat (3) @(negedge clock);
    check("rst_ops", ops, '0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_data", done_data, 8'h00);
    @(posedge clock); #1 reset = 1'b0;

    for (int i = 0; i < N; i++) preload(i, 8'($urandom));
    preload(0, 8'hA5);

    // Single transfer: two ENABLE cycles on unit 0, LOAD on unit 3 only in the second.
    send(0, 3);
    idle(1);
    wait_op(0, ENABLE, "t2_enable_timeout");
    check("t2_prime_dst", ops[3], NONE);
    @(negedge clock);
    check("t2_commit_src", ops[0], ENABLE);
    check("t2_commit_dst", ops[3], LOAD);
    @(negedge clock);
    check("t2_done", done, 1);
    check("t2_data", done_data, 8'hA5);
    drain();

    // Three back-to-back requests: FIFO fills, completions two cycles apart.
    t3_active = 1'b1;
    send(1, 2); send(3, 4); send(5, 0);
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);
    check("t3_ready_full", req_ready, 0);
    drain();
    t3_active = 1'b0;
    check("t3_done_cnt", done_times.size(), 3);
    if (done_times.size() == 3) begin
      check("t3_gap1", done_times[1] - done_times[0], 2);
      check("t3_gap2", done_times[2] - done_times[1], 2);
    end

    // Invalid requests: err pulses, never a strobe; a valid one follows normally.
    t4_active = 1'b1;
    send(4, 4); send(7, 1);
    idle(4);
    t4_active = 1'b0;
    check("t4_err_cnt", t4_err, 2);
    check("t4_no_ops", t4_ops, 0);
    d0 = done_total;
    send(2, 5);
    drain();
    check("t4_valid_done", done_total - d0, 1);

    // Reset asserted in the middle of COMMIT abandons the transfer.
    send(1, 2);
    idle(1);
    wait_op(2, LOAD, "t1_commit_timeout");
    d0 = done_total;
    #1 reset = 1'b1;
    #1;
    check("t1_ops_none", ops, '0);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    check("t1_data", done_data, 8'h00);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    repeat (6) @(negedge clock);
    check("t1_no_done", done_total - d0, 0);
    check("t1_busy_after", busy, 0);

    // Random traffic against the model.
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        s = $urandom_range(0, 7);
        d = $urandom_range(0, 7);
      end else begin
        s = $urandom_range(0, N - 1);
        d = (s + $urandom_range(1, N - 1)) % N;
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(s, d);
    end
    drain();
    check("final_queue", exp_q.size(), 0);
    check("final_err", err_seen, exp_err);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
